// File: rtl/ulpi_pkg.sv
// rtl/ulpi_pkg.sv - shared ULPI register-access constants, state encoding and widths
package ulpi_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] ULPI_FUNC_CTRL = 6'h04;
  localparam logic [ADDR_W-1:0] ULPI_OTG_CTRL  = 6'h0A;
  localparam logic [ADDR_W-1:0] ULPI_SCRATCH   = 6'h16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_WAIT  = ST_WAIT,
    S_RESP  = ST_RESP
  } arb_state_t;

endpackage

// File: rtl/ulpi_rr_pick.sv
// rtl/ulpi_rr_pick.sv - combinational round-robin picker starting after last_grant
module ulpi_rr_pick
  import ulpi_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  // Walk from farthest to nearest so the nearest requester after last_grant wins.
  always_comb begin
    valid = |req;
    idx   = '0;
    cand  = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = IDX_W'((int'(last_grant) + i) % N_REQ);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/ulpi_reg_arbiter.sv
// rtl/ulpi_reg_arbiter.sv - round-robin sequencer sharing the ULPI register port
module ulpi_reg_arbiter
  import ulpi_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int TIMEOUT = 255
) (
  input  logic                CLK_60M,
  input  logic                RST_A_USB,
  input  logic [N_REQ-1:0]    REQ,
  input  logic [N_REQ-1:0]    REQ_RW,
  input  logic [6*N_REQ-1:0]  REQ_ADDR,
  input  logic [8*N_REQ-1:0]  REQ_DATA,
  output logic [N_REQ-1:0]    ACK,
  output logic                ACK_FAIL,
  output logic [DATA_W-1:0]   RD_DATA,
  output logic                BUSY,
  input  logic                ULPI_READY,
  output logic                ULPI_REG_EN,
  output logic                ULPI_REG_RW,
  output logic [ADDR_W-1:0]   ULPI_REG_ADDR,
  output logic [DATA_W-1:0]   ULPI_REG_DATA_I,
  input  logic [DATA_W-1:0]   ULPI_REG_DATA_O,
  input  logic                ULPI_REG_DONE,
  input  logic                ULPI_REG_FAIL
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] grant, last_grant, pick_idx;
  logic             pick_valid;
  logic [WD_W-1:0]  wd, wd_inc;
  logic             grant_load, go_resp, fail_nxt, rd_load;

  ulpi_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req        (REQ),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .idx        (pick_idx)
  );

  assign wd_inc = (wd == WD_MAX) ? wd : wd + 1'b1;

  // Priority in WAIT: READY loss, then FAIL, then DONE, then watchdog expiry.
  always_comb begin
    state_nxt  = state;
    grant_load = 1'b0;
    go_resp    = 1'b0;
    fail_nxt   = 1'b0;
    rd_load    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (ULPI_READY && pick_valid) begin
          grant_load = 1'b1;
          state_nxt  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!ULPI_READY) begin
          go_resp  = 1'b1;
          fail_nxt = 1'b1;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!ULPI_READY || ULPI_REG_FAIL) begin
          go_resp  = 1'b1;
          fail_nxt = 1'b1;
        end else if (ULPI_REG_DONE) begin
          go_resp = 1'b1;
          rd_load = !ULPI_REG_RW;
        end else if (wd_inc == WD_MAX) begin
          go_resp  = 1'b1;
          fail_nxt = 1'b1;
        end
      end
      S_RESP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (go_resp) state_nxt = S_RESP;
  end

  always_ff @(posedge CLK_60M or posedge RST_A_USB) begin
    if (RST_A_USB) begin
      state           <= S_IDLE;
      grant           <= '0;
      last_grant      <= LAST_RST;
      wd              <= '0;
      ULPI_REG_EN     <= 1'b0;
      ULPI_REG_RW     <= 1'b0;
      ULPI_REG_ADDR   <= '0;
      ULPI_REG_DATA_I <= '0;
      ACK             <= '0;
      ACK_FAIL        <= 1'b0;
      RD_DATA         <= '0;
      BUSY            <= 1'b0;
    end else begin
      state       <= state_nxt;
      ULPI_REG_EN <= grant_load;
      BUSY        <= (state_nxt != S_IDLE);
      ACK         <= go_resp ? (N_REQ'(1) << grant) : '0;
      ACK_FAIL    <= go_resp & fail_nxt;
      wd          <= (state == S_WAIT) ? wd_inc : '0;
      if (grant_load) begin
        grant           <= pick_idx;
        ULPI_REG_RW     <= REQ_RW[pick_idx];
        ULPI_REG_ADDR   <= REQ_ADDR[ADDR_W*pick_idx +: ADDR_W];
        ULPI_REG_DATA_I <= REQ_DATA[DATA_W*pick_idx +: DATA_W];
      end
      if (state == S_RESP) last_grant <= grant;
      if (rd_load) RD_DATA <= ULPI_REG_DATA_O;
    end
  end

endmodule
